// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu : memory-access stage issuing dmem requests and aligning loads.
// Revision      : 1.0
// ============================================================================
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] regM_o_pc,
   input  logic [10:0] regM_o_load_store_info,
   input  logic [63:0] regM_o_regdata2,
   input  logic [63:0] regM_o_alu_result,
   input  logic [4:0]  regM_o_rd,
   input  logic        regM_o_reg_wen,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_req_we,
   output logic [63:0] dmem_req_addr,
   output logic [63:0] dmem_req_wdata,
   output logic [7:0]  dmem_req_wstrb,
   input  logic        dmem_resp_valid,
   input  logic [63:0] dmem_resp_rdata,
   output logic [63:0] mem_o_result,
   output logic [63:0] mem_o_pc,
   output logic [4:0]  mem_o_rd,
   output logic        mem_o_reg_wen,
   output logic        mem_o_stall,
   output logic        mem_o_misalign,
   output logic        mem_o_bus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [63:0] r_rdata;
   logic        r_bus_err;

   logic [10:0] w_sel;
   logic        w_present;
   logic        w_is_store;
   logic [7:0]  w_mask;
   logic [2:0]  w_amask;
   logic        w_misalign;
   logic        w_go;
   logic [5:0]  w_shamt;
   logic [63:0] w_ldata;

   // x & -x isolates the lowest set bit, so the lowest op wins on multi-hot
   assign w_sel      = regM_o_load_store_info & (~regM_o_load_store_info + 11'd1);
   assign w_present  = |regM_o_load_store_info;
   assign w_is_store = |w_sel[10:7];

   always_comb begin
      w_mask = 8'h00;
      if (w_sel[0] | w_sel[4] | w_sel[7])      w_mask = 8'h01;
      else if (w_sel[1] | w_sel[5] | w_sel[8]) w_mask = 8'h03;
      else if (w_sel[2] | w_sel[6] | w_sel[9]) w_mask = 8'h0F;
      else if (w_sel[3] | w_sel[10])           w_mask = 8'hFF;
   end

   // size-1 taken straight from the byte mask: b=000 h=001 w=011 d=111
   assign w_amask    = {w_mask[4], w_mask[2], w_mask[1]};
   assign w_misalign = w_present && (|(regM_o_alu_result[2:0] & w_amask));
   assign w_go       = w_present && !w_misalign;
   assign w_shamt    = {regM_o_alu_result[2:0], 3'b000};
   assign w_ldata    = r_rdata >> w_shamt;

   always_comb begin
      mem_o_result = regM_o_alu_result;
      if (w_sel[0])      mem_o_result = {{56{w_ldata[7]}},  w_ldata[7:0]};
      else if (w_sel[1]) mem_o_result = {{48{w_ldata[15]}}, w_ldata[15:0]};
      else if (w_sel[2]) mem_o_result = {{32{w_ldata[31]}}, w_ldata[31:0]};
      else if (w_sel[3]) mem_o_result = w_ldata;
      else if (w_sel[4]) mem_o_result = {56'd0, w_ldata[7:0]};
      else if (w_sel[5]) mem_o_result = {48'd0, w_ldata[15:0]};
      else if (w_sel[6]) mem_o_result = {32'd0, w_ldata[31:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_rdata   <= 64'd0;
         r_bus_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_bus_err <= 1'b0;
               if (w_go) begin
                  r_state <= S_REQ;
                  r_cnt   <= 16'd0;
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + 16'd1;
               if (dmem_req_ready) begin
                  r_state <= w_is_store ? S_DONE : S_WAIT;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state   <= S_DONE;
                  r_bus_err <= 1'b1;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 16'd1;
               if (dmem_resp_valid) begin
                  r_rdata <= dmem_resp_rdata;
                  r_state <= S_DONE;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state   <= S_DONE;
                  r_bus_err <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_bus_err <= 1'b0;
            end
         endcase
      end
   end

   assign dmem_req_valid = (r_state == S_REQ) && !rst;
   assign dmem_req_we    = w_is_store;
   assign dmem_req_addr  = {regM_o_alu_result[63:3], 3'b000};
   assign dmem_req_wdata = regM_o_regdata2 << w_shamt;
   assign dmem_req_wstrb = w_mask << regM_o_alu_result[2:0];

   assign mem_o_pc       = regM_o_pc;
   assign mem_o_rd       = regM_o_rd;
   assign mem_o_reg_wen  = regM_o_reg_wen && !w_misalign && !r_bus_err;
   assign mem_o_stall    = w_go && (r_state != S_DONE) && !rst;
   assign mem_o_misalign = w_misalign;
   assign mem_o_bus_err  = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_lsu : directed scoreboard bench for mem_stage_lsu.
// Revision         : 1.0
// ============================================================================
module tb_mem_stage_lsu;

   localparam logic [10:0] C_LB = 11'h001, C_LH = 11'h002, C_LW = 11'h004, C_LD = 11'h008;
   localparam logic [10:0] C_LBU = 11'h010, C_LHU = 11'h020, C_LWU = 11'h040;
   localparam logic [10:0] C_SB = 11'h080, C_SH = 11'h100, C_SD = 11'h400;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc, rd2, alu;
   logic [10:0] info;
   logic [4:0]  rd;
   logic        wen;
   logic        req_valid, req_ready, req_we, resp_valid;
   logic [63:0] req_addr, req_wdata, resp_rdata;
   logic [7:0]  req_wstrb;
   logic [63:0] res, o_pc;
   logic [4:0]  o_rd;
   logic        o_wen, stall, mis, berr;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [63:0] result;
      bit          chk_result;
      logic        wen, berr, mis;
      int          stalls;
      logic [63:0] addr, wdata;
      bit          chk_wdata;
      logic [7:0]  wstrb;
      logic        we;
   } exp_t;

   exp_t sb_q[$];

   mem_stage_lsu #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .regM_o_pc(pc), .regM_o_load_store_info(info), .regM_o_regdata2(rd2),
      .regM_o_alu_result(alu), .regM_o_rd(rd), .regM_o_reg_wen(wen),
      .dmem_req_valid(req_valid), .dmem_req_ready(req_ready), .dmem_req_we(req_we),
      .dmem_req_addr(req_addr), .dmem_req_wdata(req_wdata), .dmem_req_wstrb(req_wstrb),
      .dmem_resp_valid(resp_valid), .dmem_resp_rdata(resp_rdata),
      .mem_o_result(res), .mem_o_pc(o_pc), .mem_o_rd(o_rd), .mem_o_reg_wen(o_wen),
      .mem_o_stall(stall), .mem_o_misalign(mis), .mem_o_bus_err(berr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] r, input bit cr, input logic w, input logic be,
                               input logic m, input int st, input logic [63:0] a,
                               input logic [63:0] wd, input bit cw, input logic [7:0] ws,
                               input logic we_i);
      exp_t e;
      e.result = r; e.chk_result = cr; e.wen = w; e.berr = be; e.mis = m; e.stalls = st;
      e.addr = a; e.wdata = wd; e.chk_wdata = cw; e.wstrb = ws; e.we = we_i;
      return e;
   endfunction

   // Drives one instruction into regM, acts as memory, then retires it via the scoreboard.
   task automatic run_op(input string tag, input logic [10:0] i_info, input logic [63:0] i_alu,
                         input logic [63:0] i_rd2, input logic i_wen, input int lat,
                         input logic rsp_on, input logic [63:0] rdata, input exp_t e);
      int   nst, vcnt;
      exp_t got;
      @(negedge clk);
      info = i_info; alu = i_alu; rd2 = i_rd2; wen = i_wen;
      pc = pc + 64'd4; rd = rd + 5'd1;
      resp_valid = rsp_on; resp_rdata = rdata; req_ready = 1'b0;
      sb_q.push_back(e);
      #1;
      nst = 0; vcnt = 0;
      while (stall && nst < 40) begin
         if (req_valid) begin
            chk({tag, " addr"}, req_addr, sb_q[0].addr);
            chk({tag, " we"}, 64'(req_we), 64'(sb_q[0].we));
            chk({tag, " wstrb"}, 64'(req_wstrb), 64'(sb_q[0].wstrb));
            if (sb_q[0].chk_wdata) chk({tag, " wdata"}, req_wdata, sb_q[0].wdata);
            req_ready = (vcnt >= lat);
            vcnt++;
         end else begin
            req_ready = 1'b0;
         end
         nst++;
         @(negedge clk); #1;
      end
      got = sb_q.pop_front();
      chk({tag, " stall cycles"}, 64'(nst), 64'(got.stalls));
      if (got.chk_result) chk({tag, " result"}, res, got.result);
      chk({tag, " reg_wen"}, 64'(o_wen), 64'(got.wen));
      chk({tag, " bus_err"}, 64'(berr), 64'(got.berr));
      chk({tag, " misalign"}, 64'(mis), 64'(got.mis));
      chk({tag, " req_valid idle"}, 64'(req_valid), 64'd0);
      chk({tag, " pc"}, o_pc, pc);
      chk({tag, " rd"}, 64'(o_rd), 64'(rd));
      req_ready = 1'b0;
      @(negedge clk);
      info = 11'd0; alu = 64'd0; rd2 = 64'd0; wen = 1'b0; resp_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pc = 64'h8000_0000; rd = 5'd0; info = 11'd0; alu = 64'd0; rd2 = 64'd0;
      wen = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 64'd0;
      repeat (2) @(negedge clk);
      chk("rst req_valid", 64'(req_valid), 64'd0);
      chk("rst stall", 64'(stall), 64'd0);
      chk("rst bus_err", 64'(berr), 64'd0);
      chk("rst result", res, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst stall", 64'(stall), 64'd0);

      run_op("alu", 11'd0, 64'h1234, 64'd0, 1'b1, 0, 1'b0, 64'd0,
             mk(64'h1234, 1, 1, 0, 0, 0, 64'd0, 64'd0, 0, 8'h00, 0));
      run_op("lb", C_LB, 64'h1003, 64'd0, 1'b1, 0, 1'b1, 64'h0000_0000_8000_0000,
             mk(64'hFFFF_FFFF_FFFF_FF80, 1, 1, 0, 0, 3, 64'h1000, 64'd0, 0, 8'h08, 0));
      run_op("sh", C_SH, 64'h2006, 64'hBEEF, 1'b0, 4, 1'b0, 64'd0,
             mk(64'h2006, 1, 0, 0, 0, 6, 64'h2000, 64'hBEEF_0000_0000_0000, 1, 8'hC0, 1));
      run_op("lw misalign", C_LW, 64'h3002, 64'd0, 1'b1, 0, 1'b0, 64'd0,
             mk(64'd0, 0, 0, 0, 1, 0, 64'd0, 64'd0, 0, 8'h00, 0));
      run_op("ld timeout", C_LD, 64'h4000, 64'd0, 1'b1, 0, 1'b0, 64'd0,
             mk(64'd0, 0, 0, 1, 0, 9, 64'h4000, 64'd0, 0, 8'hFF, 0));
      run_op("lbu", C_LBU, 64'h1003, 64'd0, 1'b1, 0, 1'b1, 64'h0000_0000_8000_0000,
             mk(64'h80, 1, 1, 0, 0, 3, 64'h1000, 64'd0, 0, 8'h08, 0));
      run_op("lhu", C_LHU, 64'h1006, 64'd0, 1'b1, 0, 1'b1, 64'hABCD_0000_0000_0000,
             mk(64'hABCD, 1, 1, 0, 0, 3, 64'h1000, 64'd0, 0, 8'hC0, 0));
      run_op("lh", C_LH, 64'h1006, 64'd0, 1'b1, 0, 1'b1, 64'hABCD_0000_0000_0000,
             mk(64'hFFFF_FFFF_FFFF_ABCD, 1, 1, 0, 0, 3, 64'h1000, 64'd0, 0, 8'hC0, 0));
      run_op("lw", C_LW, 64'h1004, 64'd0, 1'b1, 0, 1'b1, 64'h8765_4321_0000_0000,
             mk(64'hFFFF_FFFF_8765_4321, 1, 1, 0, 0, 3, 64'h1000, 64'd0, 0, 8'hF0, 0));
      run_op("lwu", C_LWU, 64'h1004, 64'd0, 1'b1, 0, 1'b1, 64'h8765_4321_0000_0000,
             mk(64'h0000_0000_8765_4321, 1, 1, 0, 0, 3, 64'h1000, 64'd0, 0, 8'hF0, 0));
      run_op("ld", C_LD, 64'h5000, 64'd0, 1'b1, 0, 1'b1, 64'h0123_4567_89AB_CDEF,
             mk(64'h0123_4567_89AB_CDEF, 1, 1, 0, 0, 3, 64'h5000, 64'd0, 0, 8'hFF, 0));
      run_op("ld misalign", C_LD, 64'h8004, 64'd0, 1'b1, 0, 1'b0, 64'd0,
             mk(64'd0, 0, 0, 0, 1, 0, 64'd0, 64'd0, 0, 8'h00, 0));
      run_op("sb", C_SB, 64'h7005, 64'h1122_3344_5566_77AA, 1'b0, 0, 1'b0, 64'd0,
             mk(64'h7005, 1, 0, 0, 0, 2, 64'h7000, 64'h6677_AA00_0000_0000, 1, 8'h20, 1));
      run_op("sd", C_SD, 64'h6000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0, 1'b0, 64'd0,
             mk(64'h6000, 1, 0, 0, 0, 2, 64'h6000, 64'hDEAD_BEEF_CAFE_F00D, 1, 8'hFF, 1));
      run_op("multihot", C_LB | C_SD, 64'h1003, 64'd0, 1'b1, 0, 1'b1, 64'h0000_0000_8000_0000,
             mk(64'hFFFF_FFFF_FFFF_FF80, 1, 1, 0, 0, 3, 64'h1000, 64'd0, 0, 8'h08, 0));

      // lwu parked in WAIT (no response), then reset mid-operation
      @(negedge clk);
      info = C_LWU; alu = 64'h4000; wen = 1'b1; req_ready = 1'b1; resp_valid = 1'b0;
      @(negedge clk); #1;
      chk("rstmid req_valid in REQ", 64'(req_valid), 64'd1);
      @(negedge clk); #1;
      chk("rstmid stall in WAIT", 64'(stall), 64'd1);
      chk("rstmid req_valid in WAIT", 64'(req_valid), 64'd0);
      rst = 1'b1; req_ready = 1'b0;
      #1;
      chk("rstmid stall during rst", 64'(stall), 64'd0);
      @(negedge clk);
      rst = 1'b0; info = 11'd0; alu = 64'd0; wen = 1'b0;
      resp_valid = 1'b1; resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rstmid req_valid after", 64'(req_valid), 64'd0);
         chk("rstmid stall after", 64'(stall), 64'd0);
         chk("rstmid bus_err after", 64'(berr), 64'd0);
         @(negedge clk);
      end
      resp_valid = 1'b0;

      run_op("ld recover", C_LD, 64'h5008, 64'd0, 1'b1, 0, 1'b1, 64'hCAFE_0000_1234_5678,
             mk(64'hCAFE_0000_1234_5678, 1, 1, 0, 0, 3, 64'h5008, 64'd0, 0, 8'hFF, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage; sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Issues data-memory requests for loads and stores over a valid/ready request channel with a separate response channel.
- Aligns load data with sign or zero extension, and selects the writeback result for the MEM/WB register.
- Holds the pipeline through a stall output until the access completes or times out.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before aborting with bus error (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
regM_o_pc  in  64  instruction PC; passed through to mem_o_pc
regM_o_load_store_info  in  11  one-hot: [0]lb [1]lh [2]lw [3]ld [4]lbu [5]lhu [6]lwu [7]sb [8]sh [9]sw [10]sd; all-zero = no memory op
regM_o_regdata2  in  64  store data
regM_o_alu_result  in  64  effective address / ALU result
regM_o_rd  in  5  destination register
regM_o_reg_wen  in  1  writeback enable
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1=store
dmem_req_addr  out  64  doubleword-aligned address {alu_result[63:3],3'b0}
dmem_req_wdata  out  64  regdata2 << (8*alu_result[2:0])
dmem_req_wstrb  out  8  byte strobes, size mask << alu_result[2:0]
dmem_resp_valid  in  1  load data valid
dmem_resp_rdata  in  64  load doubleword
mem_o_result  out  64  load: aligned/extended data; otherwise alu_result
mem_o_pc  out  64  = regM_o_pc
mem_o_rd  out  5  = regM_o_rd
mem_o_reg_wen  out  1  reg_wen, suppressed on misalign/bus error
mem_o_stall  out  1  hold regM and upstream stages; bubble regW
mem_o_misalign  out  1  current op is not naturally aligned
mem_o_bus_err  out  1  current op timed out

Behaviour:
- Multiple one-hot bits set: lowest set bit wins.
- Op size: b=1, h=2, w=4, d=8 bytes.
- Misaligned: address not a multiple of op size.
- FSM states: IDLE, REQ, WAIT, DONE; state and all registers clear to IDLE/0 on rst.
- IDLE:
  - Aligned memory op present: -> REQ next edge.
  - Misaligned op: stays IDLE, no request; mem_o_misalign=1 and mem_o_reg_wen=0 combinationally, stall=0; trap handling is downstream.
  - No op: passthrough, stall=0.
- REQ:
  - dmem_req_valid=1; addr, wdata, wstrb, we driven combinationally from held regM inputs (stable because stall=1).
  - Handshake on valid&&ready: store -> DONE; load -> WAIT.
  - Valid must not drop before ready except on rst or timeout.
- WAIT: on dmem_resp_valid, capture rdata into rdata_q -> DONE. resp_valid in any other state is ignored.
- DONE:
  - Stall=0 for exactly one cycle; instruction advances -> IDLE next edge.
  - Load result: (rdata_q >> 8*addr[2:0]) truncated to size; sign-extend lb/lh/lw, zero-extend lbu/lhu/lwu; ld unchanged.
- mem_o_stall = memory op present && aligned && state!=DONE; forced 0 while rst.
- Latency with ready and resp both same-cycle: store 2 stall cycles, load 3 stall cycles.
- Timeout:
  - cnt counts cycles in REQ+WAIT, cleared on entry to REQ.
  - cnt==TIMEOUT_CYCLES-1 without completion: -> DONE, bus_err_q=1, mem_o_reg_wen=0, dmem_req_valid deasserted.
  - bus_err_q clears on IDLE entry.
- Reset mid-operation: next edge returns to IDLE, dmem_req_valid=0, stall=0; late responses ignored.
- Reset values: dmem_req_valid=0, stall=0, bus_err=0, rdata_q=0.
  - Passthrough outputs follow inputs, which are zero because regM clears on rst; mem_o_result=0 under a cleared regM.
- Non-memory ops: mem_o_result=alu_result, zero-cycle passthrough, dmem_req_valid=0.

Test Plan:
- ALU op, load_store_info=0, alu_result=0x1234 -> mem_o_result=0x1234, stall=0, dmem_req_valid never asserted.
- lb, addr=0x1003, ready=1, resp same cycle as WAIT entry, rdata=0x00000000_80000000 -> req_addr=0x1000; byte3=0x80; result=0xFFFF_FFFF_FFFF_FF80; 3 stall cycles.
- sh, addr=0x2006, regdata2=0xBEEF -> wstrb=0xC0, wdata=0xBEEF_0000_0000_0000, we=1; ready held low 4 cycles keeps valid/addr stable and stall=1.
- lw, addr=0x3002 -> misalign=1, reg_wen=0, no request, stall=0.
- ld, TIMEOUT_CYCLES=8, ready=1, resp never arrives -> bus_err=1 in DONE, reg_wen=0, stall drops after 8 cycles in REQ+WAIT.
- lwu in WAIT, rst pulsed -> next cycle IDLE, req_valid=0, stall=0; subsequent resp_valid causes no state change.
